// File: rtl/ballot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ballot_pkg: state codes, candidate codes and defaults shared by the  |
// | ballot station, the tally machine and the bench.   Revision: 1.0     |
// +----------------------------------------------------------------------+
package ballot_pkg;

  localparam int DEF_CNT_W = 21;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SESSION = 3'd1;
  localparam logic [2:0] ST_CONFIRM = 3'd2;
  localparam logic [2:0] ST_EMIT    = 3'd3;
  localparam logic [2:0] ST_LOCKED  = 3'd4;

  typedef enum logic [1:0] {
    CAND_A = 2'd0,
    CAND_B = 2'd1,
    CAND_C = 2'd2,
    CAND_D = 2'd3
  } cand_e;

  // One-hot strobe vector ordered {d, c, b, a}.
  function automatic logic [3:0] strobe_decode(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ballot_station_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ballot_station_if: voter inputs and one-hot vote strobes.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ballot_station_if;
  logic       card_in;
  logic       sel_valid;
  logic [1:0] sel;
  logic       confirm;
  logic       cancel;
  logic       a;
  logic       b;
  logic       c;
  logic       d;

  modport master (
    output card_in, sel_valid, sel, confirm, cancel,
    input  a, b, c, d
  );

  modport slave (
    input  card_in, sel_valid, sel, confirm, cancel,
    output a, b, c, d
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: up counter with enable and synchronous clear that holds |
// | at all-ones instead of wrapping.                   Revision: 1.0     |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ballot_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ballot_station: one voting session per card, one strobe per ballot,  |
// | with ballot and abort counters.                    Revision: 1.0     |
// +----------------------------------------------------------------------+
module ballot_station
  import ballot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  ballot_station_if.slave   bus,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  ballots_cast,
  output logic [CNT_W-1:0]  aborts
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state, state_nxt;
  logic [1:0]  choice, choice_nxt;
  logic [15:0] timer, timer_nxt;
  logic        abort_inc;
  logic        ballot_inc;

  always_comb begin
    state_nxt  = state;
    choice_nxt = choice;
    timer_nxt  = timer;
    abort_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.card_in) begin
          state_nxt = ST_SESSION;
          timer_nxt = '0;
        end
      end
      ST_SESSION: begin
        if (!bus.card_in) begin
          state_nxt = ST_IDLE;
          abort_inc = 1'b1;
        end else if (bus.sel_valid) begin
          choice_nxt = bus.sel;
          state_nxt  = ST_CONFIRM;
          timer_nxt  = '0;
        end else if (timer == TIMER_LAST) begin
          state_nxt = ST_LOCKED;
          abort_inc = 1'b1;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      // confirm outranks sel_valid, so a same-cycle reselect commits the old choice.
      ST_CONFIRM: begin
        if (!bus.card_in) begin
          state_nxt = ST_IDLE;
          abort_inc = 1'b1;
        end else if (bus.confirm) begin
          state_nxt = ST_EMIT;
        end else if (bus.cancel) begin
          state_nxt = ST_SESSION;
          timer_nxt = '0;
        end else if (bus.sel_valid) begin
          choice_nxt = bus.sel;
          timer_nxt  = '0;
        end else if (timer == TIMER_LAST) begin
          state_nxt = ST_LOCKED;
          abort_inc = 1'b1;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      ST_EMIT: begin
        state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!bus.card_in) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      choice <= 2'd0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      choice <= choice_nxt;
      timer  <= timer_nxt;
    end
  end

  assign ballot_inc = (state == ST_EMIT);

  // Strobes come from registers only; no input reaches them combinationally.
  assign {bus.d, bus.c, bus.b, bus.a} = (state == ST_EMIT) ? strobe_decode(choice) : 4'b0000;

  assign busy    = (state != ST_IDLE);
  assign state_o = state;

  sat_counter #(.W(CNT_W)) u_ballots (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (ballot_inc),
    .count (ballots_cast)
  );

  sat_counter #(.W(CNT_W)) u_aborts (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (abort_inc),
    .count (aborts)
  );

endmodule
`default_nettype wire

// File: tb/tb_ballot_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ballot_station: directed scenarios plus random sessions, checked  |
// | against a session-level model and a tally of the strobes.  Rev 1.0   |
// +----------------------------------------------------------------------+
module tb_ballot_station;
  import ballot_pkg::*;

  localparam int T = 4;
  localparam int W = DEF_CNT_W;
  localparam longint CNT_MAX = (64'd1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ballot_station_if bus ();
  logic         busy;
  logic [2:0]   state_o;
  logic [W-1:0] ballots_cast;
  logic [W-1:0] aborts;

  ballot_station #(.TIMEOUT_CYCLES(T), .CNT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .state_o      (state_o),
    .ballots_cast (ballots_cast),
    .aborts       (aborts)
  );

  int checks = 0;
  int errors = 0;

  // Session-level model: where the voter is, what they picked, how long idle.
  int     m_mode;
  int     m_choice;
  int     m_idle;
  longint m_ballots;
  longint m_aborts;
  int     tally [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat_inc(input longint v);
    return (v >= CNT_MAX) ? v : v + 1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_choice = 0; m_idle = 0; m_ballots = 0; m_aborts = 0;
    end else begin
      case (m_mode)
        0: if (bus.card_in) begin m_mode = 1; m_idle = 0; end
        1: begin
          if (!bus.card_in) begin m_mode = 0; m_aborts = sat_inc(m_aborts); end
          else if (bus.sel_valid) begin m_choice = int'(bus.sel); m_mode = 2; m_idle = 0; end
          else if (m_idle + 1 >= T) begin m_mode = 4; m_aborts = sat_inc(m_aborts); end
          else m_idle++;
        end
        2: begin
          if (!bus.card_in) begin m_mode = 0; m_aborts = sat_inc(m_aborts); end
          else if (bus.confirm) m_mode = 3;
          else if (bus.cancel) begin m_mode = 1; m_idle = 0; end
          else if (bus.sel_valid) begin m_choice = int'(bus.sel); m_idle = 0; end
          else if (m_idle + 1 >= T) begin m_mode = 4; m_aborts = sat_inc(m_aborts); end
          else m_idle++;
        end
        3: begin m_mode = 4; m_ballots = sat_inc(m_ballots); end
        default: if (!bus.card_in) m_mode = 0;
      endcase
    end
  endtask

  task automatic check_all();
    logic [3:0] strobes;
    logic [3:0] exp_strobes;
    strobes     = {bus.d, bus.c, bus.b, bus.a};
    exp_strobes = (m_mode == 3) ? (4'b0001 << m_choice) : 4'b0000;
    check("state", state_o, m_mode);
    check("busy", busy, (m_mode != 0));
    check("strobes", strobes, exp_strobes);
    check("ballots_cast", ballots_cast, m_ballots);
    check("aborts", aborts, m_aborts);
    check("onehot", ($countones(strobes) <= 1), 1);
    check("tally_sum", ballots_cast + (m_mode == 3 ? 1 : 0),
          tally[0] + tally[1] + tally[2] + tally[3]);
  endtask

  // Tally counts strobes as the tally machine would; ballots_cast lags one edge.
  task automatic tick();
    logic rst_s;
    rst_s = rst;
    model_step();
    @(posedge clk);
    #1;
    if (rst_s) begin
      for (int i = 0; i < 4; i++) tally[i] = 0;
    end
    if (bus.a) tally[0]++;
    if (bus.b) tally[1]++;
    if (bus.c) tally[2]++;
    if (bus.d) tally[3]++;
    check_all();
  endtask

  task automatic step(input logic card, input logic sv, input logic [1:0] s,
                      input logic conf, input logic canc);
    bus.card_in   = card;
    bus.sel_valid = sv;
    bus.sel       = s;
    bus.confirm   = conf;
    bus.cancel    = canc;
    tick();
  endtask

  initial begin
    int     len;
    logic   rc;
    longint b0;
    for (int i = 0; i < 4; i++) tally[i] = 0;
    m_mode = 0; m_choice = 0; m_idle = 0; m_ballots = 0; m_aborts = 0;

    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("reset_state", state_o, ST_IDLE);
    check("reset_busy", busy, 0);
    check("reset_ballots", ballots_cast, 0);
    rst = 1'b0;

    // Basic vote for c.
    step(1, 0, 0, 0, 0);
    step(1, 1, CAND_C, 0, 0);
    step(1, 0, 0, 1, 0);
    check("basic_c_high", bus.c, 1);
    check("basic_abd_low", {bus.a, bus.b, bus.d}, 0);
    step(1, 0, 0, 0, 0);
    check("basic_c_one_cycle", bus.c, 0);
    check("basic_ballots", ballots_cast, 1);
    check("basic_locked", state_o, ST_LOCKED);
    check("basic_tally_c", tally[2], 1);
    step(1, 0, 0, 0, 0);
    check("basic_still_locked", state_o, ST_LOCKED);
    step(0, 0, 0, 0, 0);
    check("basic_idle", state_o, ST_IDLE);

    // Re-select a then d.
    step(1, 0, 0, 0, 0);
    step(1, 1, CAND_A, 0, 0);
    step(1, 1, CAND_D, 0, 0);
    step(1, 0, 0, 1, 0);
    check("resel_d", bus.d, 1);
    check("resel_not_a", bus.a, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Cancel then confirm: confirm ignored in SESSION.
    step(1, 0, 0, 0, 0);
    step(1, 1, CAND_B, 0, 0);
    step(1, 0, 0, 0, 1);
    check("cancel_session", state_o, ST_SESSION);
    step(1, 0, 0, 1, 0);
    check("cancel_no_strobe", {bus.d, bus.c, bus.b, bus.a}, 0);
    check("cancel_still_session", state_o, ST_SESSION);
    step(0, 0, 0, 0, 0);
    check("cancel_abort", aborts, 1);

    // Timeout.
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < T - 1; i++) step(1, 0, 0, 0, 0);
    check("timeout_pre", state_o, ST_SESSION);
    step(1, 0, 0, 0, 0);
    check("timeout_locked", state_o, ST_LOCKED);
    check("timeout_abort", aborts, 1);
    step(1, 0, 0, 0, 0);
    check("timeout_no_new", state_o, ST_LOCKED);
    step(0, 0, 0, 0, 0);

    // Card pulled in CONFIRM.
    step(1, 0, 0, 0, 0);
    step(1, 1, CAND_A, 0, 0);
    step(0, 0, 0, 0, 0);
    check("pull_idle", state_o, ST_IDLE);
    check("pull_abort", aborts, 2);

    // Held card cannot vote twice.
    step(1, 0, 0, 0, 0);
    step(1, 1, CAND_B, 0, 0);
    step(1, 0, 0, 1, 0);
    b0 = longint'(ballots_cast);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    check("double_vote", ballots_cast, b0 + 1);
    step(0, 0, 0, 0, 0);

    // confirm with sel_valid commits old choice; EMIT goes to LOCKED despite pull.
    step(1, 0, 0, 0, 0);
    step(1, 1, CAND_B, 0, 0);
    step(1, 1, CAND_A, 1, 0);
    check("simul_b", bus.b, 1);
    check("simul_not_a", bus.a, 0);
    step(0, 0, 0, 0, 0);
    check("emit_to_locked", state_o, ST_LOCKED);
    step(0, 0, 0, 0, 0);

    // Reset during EMIT.
    step(1, 0, 0, 0, 0);
    step(1, 1, CAND_D, 0, 0);
    step(1, 0, 0, 1, 0);
    check("pre_rst_d", bus.d, 1);
    rst = 1'b1;
    step(1, 0, 0, 0, 0);
    check("rst_emit_d", bus.d, 0);
    check("rst_emit_ballots", ballots_cast, 0);
    check("rst_emit_aborts", aborts, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);

    // Random sessions.
    for (int s = 0; s < 200; s++) begin
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        rc = ($urandom_range(0, 19) != 0);
        step(rc, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      end
      step(0, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ballot_station.md
Name: ballot_station

Overview:
- Voter-facing front end that drives the one-hot vote strobes a/b/c/d consumed by the tally machine (four 21-bit counters plus winner compare).
- Runs one voting session per inserted card: select, optionally re-select or cancel, confirm.
- Emits exactly one single-cycle strobe per confirmed ballot, then locks out until the card is removed.
- Keeps its own ballot and abort counters so the counts can be cross-checked against the tally sum A+B+C+D.

Parameters:
- TIMEOUT_CYCLES, 16: idle cycles allowed in SESSION/CONFIRM before the session aborts; legal range 2..65535.
- CNT_W, 21: width of ballots_cast and aborts; matches the tally counter width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- card_in  input  1  level; high while a voter card is inserted.
- sel_valid  input  1  one-cycle pulse; sel is valid this cycle.
- sel  input  2  candidate code: 0=a, 1=b, 2=c, 3=d.
- confirm  input  1  one-cycle pulse; commit the latched choice.
- cancel  input  1  one-cycle pulse; discard the latched choice.
- a, b, c, d  output  1 each  vote strobes; at most one is high, for exactly one cycle.
- busy  output  1  high in every state except IDLE.
- state_o  output  3  current FSM state encoding, for debug.
- ballots_cast  output  CNT_W  confirmed ballots since reset; saturates at all-ones.
- aborts  output  CNT_W  sessions ended without a vote; saturates at all-ones.

Behaviour:
- Reset (rst high at posedge): state=IDLE; choice=0; timer=0; counters=0; a..d=0; busy=0. Reset wins over every other input, including mid-session and during EMIT, where the strobe is dropped.
- States: IDLE=0, SESSION=1, CONFIRM=2, EMIT=3, LOCKED=4. Codes 5-7 recover to IDLE on the next edge.
- IDLE: card_in=1 -> SESSION, timer cleared. A card already present when reset releases starts a session.
- SESSION:
  - card_in=0 -> IDLE, aborts+1.
  - Else sel_valid -> latch sel into choice, go to CONFIRM, timer cleared.
  - Else timer==TIMEOUT_CYCLES-1 -> LOCKED, aborts+1.
  - Else timer+1.
  - confirm and cancel are ignored in SESSION.
- CONFIRM, priority order:
  1. card_in=0 -> IDLE, aborts+1.
  2. confirm -> EMIT.
  3. cancel -> SESSION, timer cleared.
  4. sel_valid -> re-latch choice, stay in CONFIRM, timer cleared.
  5. Timeout -> LOCKED, aborts+1.
  - confirm together with sel_valid commits the OLD choice.
- EMIT:
  - Lasts exactly one cycle; next state is always LOCKED, even if the card was pulled.
  - The strobe for the latched choice is high for this whole cycle.
  - ballots_cast+1 at the edge leaving EMIT.
- LOCKED: stays until card_in=0, then IDLE. A card held in keeps the station locked, so one card yields at most one vote.
- Outputs:
  - a..d are decoded from the registered state and choice only; there is no combinational path from any input.
  - Latency: confirm sampled at edge N -> strobe high from edge N to edge N+1.
  - Strobes are never high outside EMIT.
- Counters: unsigned CNT_W bits; they hold at 2^CNT_W-1 instead of wrapping.
- Timer: 16 bits; counts only in SESSION and CONFIRM and is cleared on entry to either state.

Decomposition:
- Shared package ballot_pkg holds the state encodings, the candidate codes (CAND_A..CAND_D = 0..3) and the CNT_W default. The tally machine and bench use the same candidate codes.
- One sub-module, sat_counter (enable, synchronous clear, saturate at max), instantiated twice for ballots_cast and aborts.

Test Plan:
- Basic vote: rst 2 cycles; card_in=1; sel_valid with sel=2; confirm -> c=1 for exactly 1 cycle, a/b/d=0; ballots_cast=1; state=LOCKED until card_in=0, then IDLE.
- Re-select and cancel:
  - sel=0, then sel=3, then confirm -> d pulses once, not a.
  - Second session: sel=1, cancel, confirm -> no strobe; state=SESSION.
- Timeout: TIMEOUT_CYCLES=4; card_in=1 with no further input -> LOCKED after 4 cycles; aborts=1; no strobe; a fifth cycle of card_in=1 gives no new session.
- Abort and double vote:
  - Card pulled in CONFIRM -> IDLE, aborts+1, no strobe.
  - Card held after a vote with repeated confirm pulses -> ballots_cast unchanged.
- Simultaneous events and reset:
  - confirm and sel_valid(sel=0) together while choice=1 -> b pulses.
  - rst asserted during EMIT -> strobe low on the next cycle; all counters 0.
- Integration: ballot_station drives the tally machine for 200 random sessions -> A+B+C+D equals ballots_cast every cycle; at most one strobe high in any cycle.
